// File: rtl/data_path_rf_pkg.sv
// Shared opcodes, widths and FSM state for the data_path_rf register-file datapath.
package dp_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SHL = 3'd5;
  localparam logic [OP_W-1:0] OP_SHR = 3'd6;
  localparam logic [OP_W-1:0] OP_MUL = 3'd7;

  typedef enum logic {IDLE, MUL} dp_state_t;

endpackage

// File: rtl/data_path_rf_seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one partial product per cycle.
// Only present when DATA_PATH_MUL_EN is defined; done and product are valid during the final step.
`ifdef DATA_PATH_MUL_EN
module seq_multiplier #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BIT_WIDTH-1:0]   a,
  input  logic [BIT_WIDTH-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [2*BIT_WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(BIT_WIDTH + 1);

  logic [2*BIT_WIDTH-1:0] r_mcand;
  logic [2*BIT_WIDTH-1:0] r_acc;
  logic [BIT_WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]       r_count;
  logic                   r_busy;
  logic [2*BIT_WIDTH-1:0] w_accNext;
  logic                   w_lastStep;

  // The product is exposed combinationally so the final step's edge can commit it.
  assign w_accNext  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_lastStep = r_busy && (r_count == CNT_W'(1));
  assign busy       = r_busy;
  assign done       = w_lastStep;
  assign product    = w_accNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (start && !r_busy) begin
      r_mcand  <= {{BIT_WIDTH{1'b0}}, a};
      r_acc    <= '0;
      r_mplier <= b;
      r_count  <= CNT_W'(BIT_WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - CNT_W'(1);
      if (w_lastStep) r_busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/data_path_rf.sv
// data_path_rf: register file, 8-op ALU with registered carry/zero, output register, valid/ready issue.
// Define DATA_PATH_MUL_EN to make opcode 7 an iterative multiply that stalls op_ready; otherwise it is PASS_B.
module data_path_rf
  import dp_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int REG_COUNT = 4,
  parameter int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [OP_W-1:0]      op_code,
  input  logic                 sel_in,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [ADDR_W-1:0]    addr_b,
  input  logic [ADDR_W-1:0]    addr_w,
  input  logic                 wr_en,
  input  logic                 out_en,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 cout,
  output logic                 zero
);

  logic [BIT_WIDTH-1:0] r_rf [REG_COUNT];
  logic [BIT_WIDTH-1:0] r_out;
  logic                 r_cout;
  logic                 r_zero;

  logic [BIT_WIDTH-1:0] w_a;
  logic [BIT_WIDTH-1:0] w_b;
  logic [BIT_WIDTH:0]   w_sum;
  logic [BIT_WIDTH:0]   w_diff;
  logic [BIT_WIDTH-1:0] w_aluRes;
  logic                 w_aluCarry;
  logic                 w_accept;
  logic                 w_single;
  logic                 w_mulStart;
  logic                 w_mulDone;
  logic                 w_mulWrEn;
  logic [ADDR_W-1:0]    w_mulAddr;
  logic [BIT_WIDTH-1:0] w_mulLow;
  logic                 w_mulCarry;

  assign w_a    = r_rf[addr_a];
  assign w_b    = r_rf[addr_b];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + {{BIT_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_aluRes   = '0;
    w_aluCarry = 1'b0;
    case (op_code)
      OP_ADD: {w_aluCarry, w_aluRes} = w_sum;
      OP_SUB: {w_aluCarry, w_aluRes} = w_diff;
      OP_AND: w_aluRes = w_a & w_b;
      OP_OR:  w_aluRes = w_a | w_b;
      OP_XOR: w_aluRes = w_a ^ w_b;
      OP_SHL: begin
        w_aluRes   = {w_a[BIT_WIDTH-2:0], 1'b0};
        w_aluCarry = w_a[BIT_WIDTH-1];
      end
      OP_SHR: begin
        w_aluRes   = {1'b0, w_a[BIT_WIDTH-1:1]};
        w_aluCarry = w_a[0];
      end
      default: begin
`ifndef DATA_PATH_MUL_EN
        w_aluRes = w_b;
`endif
      end
    endcase
  end

`ifdef DATA_PATH_MUL_EN
  dp_state_t              r_state;
  dp_state_t              w_nextState;
  logic [ADDR_W-1:0]      r_mulAddr;
  logic                   r_mulWrEn;
  logic                   w_mulBusy;
  logic [2*BIT_WIDTH-1:0] w_product;

  assign w_mulStart = w_accept && !sel_in && (op_code == OP_MUL);
  assign op_ready   = rst_n && (r_state == IDLE) && !w_mulBusy;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_mulStart) w_nextState = MUL;
      MUL:     if (w_mulDone)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Destination is captured at accept so the handshake inputs are free while the multiply runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mulAddr <= '0;
      r_mulWrEn <= 1'b0;
    end else if (w_mulStart) begin
      r_mulAddr <= addr_w;
      r_mulWrEn <= wr_en;
    end
  end

  seq_multiplier #(.BIT_WIDTH(BIT_WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mulStart),
    .a       (w_a),
    .b       (w_b),
    .busy    (w_mulBusy),
    .done    (w_mulDone),
    .product (w_product)
  );

  assign w_mulAddr  = r_mulAddr;
  assign w_mulWrEn  = r_mulWrEn;
  assign w_mulLow   = w_product[BIT_WIDTH-1:0];
  assign w_mulCarry = |w_product[2*BIT_WIDTH-1:BIT_WIDTH];
`else
  assign w_mulStart = 1'b0;
  assign w_mulDone  = 1'b0;
  assign w_mulWrEn  = 1'b0;
  assign w_mulAddr  = '0;
  assign w_mulLow   = '0;
  assign w_mulCarry = 1'b0;
  assign op_ready   = rst_n;
`endif

  assign w_accept = op_valid && op_ready;
  assign w_single = w_accept && !w_mulStart;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
    end else if (w_single && wr_en) begin
      r_rf[addr_w] <= sel_in ? in_data : w_aluRes;
    end else if (w_mulDone && w_mulWrEn) begin
      r_rf[w_mulAddr] <= w_mulLow;
    end
  end

  // Loading from in_data leaves the flags alone; only ALU results update them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (w_accept && out_en) r_out <= w_a;
      if (w_single && !sel_in) begin
        r_cout <= w_aluCarry;
        r_zero <= (w_aluRes == '0);
      end else if (w_mulDone) begin
        r_cout <= w_mulCarry;
        r_zero <= (w_mulLow == '0);
      end
    end
  end

  assign out  = r_out;
  assign cout = r_cout;
  assign zero = r_zero;

endmodule

// File: tb/tb_data_path_rf.sv
// tb_data_path_rf: directed and randomized checks of data_path_rf against an arithmetic reference model.
// Covers the DATA_PATH_MUL_EN build when that macro is defined.
module tb_data_path_rf;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int AW   = 2;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic          sel_in;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-1:0] addr_w;
  logic          wr_en;
  logic          out_en;
  logic [W-1:0]  in_data;
  logic [W-1:0]  out;
  logic          cout;
  logic          zero;

  int checksRun    = 0;
  int checksPassed = 0;
  int mRf [N];
  int mOut, mCout, mZero;

  always #5 clk = ~clk;

  data_path_rf #(.BIT_WIDTH(W), .REG_COUNT(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .sel_in   (sel_in),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .addr_w   (addr_w),
    .wr_en    (wr_en),
    .out_en   (out_en),
    .in_data  (in_data),
    .out      (out),
    .cout     (cout),
    .zero     (zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksRun++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Reference ALU written from the operation table with plain integer arithmetic.
  task automatic modelAlu(input int code, input int a, input int b, output int res, output int c);
    res = 0;
    c   = 0;
    case (code)
      0: begin res = (a + b) & MASK; c = (a + b) > MASK; end
      1: begin res = (a - b) & MASK; c = (a >= b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * 2) & MASK; c = a / (1 << (W - 1)); end
      6: begin res = a / 2; c = a % 2; end
      default: begin
`ifdef DATA_PATH_MUL_EN
        res = (a * b) & MASK;
        c   = (a * b) > MASK;
`else
        res = b;
`endif
      end
    endcase
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, " out"}, 32'(out), mOut);
    checkOutput({tag, " cout"}, 32'(cout), mCout);
    checkOutput({tag, " zero"}, 32'(zero), mZero);
    checkOutput({tag, " op_ready"}, 32'(op_ready), 1);
  endtask

  task automatic driveInputs(input bit v, input int code, input bit s, input int aa, input int ab,
                             input int aw, input bit we, input bit oe, input int din);
    op_valid = v;
    op_code  = code[2:0];
    sel_in   = s;
    addr_a   = aa[AW-1:0];
    addr_b   = ab[AW-1:0];
    addr_w   = aw[AW-1:0];
    wr_en    = we;
    out_en   = oe;
    in_data  = din[W-1:0];
  endtask

  // One single-cycle operation: model is updated from pre-edge contents, DUT sampled 1ns after the edge.
  task automatic applyStimulus(input bit v, input int code, input bit s, input int aa, input int ab,
                               input int aw, input bit we, input bit oe, input int din);
    int res, c;
    driveInputs(v, code, s, aa, ab, aw, we, oe, din);
    if (v) begin
      modelAlu(code, mRf[aa], mRf[ab], res, c);
      if (oe) mOut = mRf[aa];
      if (we) mRf[aw] = s ? din : res;
      if (!s) begin
        mCout = c;
        mZero = (res == 0);
      end
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic loadReg(input int idx, input int val);
    applyStimulus(1'b1, 0, 1'b1, 0, 0, idx, 1'b1, 1'b0, val);
  endtask

  task automatic readReg(input string tag, input int idx);
    applyStimulus(1'b1, 0, 1'b1, idx, 0, 0, 1'b0, 1'b1, 0);
    checkOutput(tag, 32'(out), mRf[idx]);
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) mRf[i] = 0;
    mOut  = 0;
    mCout = 0;
    mZero = 0;
  endtask

`ifdef DATA_PATH_MUL_EN
  task automatic runMul(input string tag, input int aa, input int ab, input int aw, input bit we, input bit oe);
    int p, lowCycles;
    driveInputs(1'b1, 7, 1'b0, aa, ab, aw, we, oe, 0);
    p = mRf[aa] * mRf[ab];
    if (oe) mOut = mRf[aa];
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
    lowCycles = 0;
    while (op_ready !== 1'b1 && lowCycles < 4 * W) begin
      lowCycles++;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, " stall cycles"}, lowCycles, W);
    if (we) mRf[aw] = p & MASK;
    mCout = (p > MASK);
    mZero = ((p & MASK) == 0);
    checkState(tag);
  endtask
`endif

  initial begin
    bit v, s, we, oe;
    int code, aa, ab, aw, din, lowCycles;
    bit heldEarly;

    driveInputs(1'b0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset op_ready low", 32'(op_ready), 0);
    checkOutput("reset out", 32'(out), 0);
    checkOutput("reset cout", 32'(cout), 0);
    checkOutput("reset zero", 32'(zero), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("release op_ready", 32'(op_ready), 1);
    for (int i = 0; i < N; i++) readReg("reset rf", i);

    // Loads leave flags alone; ADD 0xF0+0x20 wraps with carry.
    loadReg(0, 'hF0);
    loadReg(1, 'h20);
    checkOutput("load keeps cout", 32'(cout), 0);
    applyStimulus(1'b1, 0, 1'b0, 0, 1, 2, 1'b1, 1'b0, 0);
    checkOutput("add cout", 32'(cout), 1);
    checkOutput("add zero", 32'(zero), 0);
    readReg("add r2", 2);
    checkOutput("add r2 literal", 32'(out), 'h10);

    applyStimulus(1'b1, 1, 1'b0, 1, 1, 3, 1'b1, 1'b0, 0);
    checkOutput("sub self zero", 32'(zero), 1);
    checkOutput("sub self cout", 32'(cout), 1);
    readReg("sub r3", 3);
    loadReg(0, 'h01);
    applyStimulus(1'b1, 6, 1'b0, 0, 0, 3, 1'b1, 1'b0, 0);
    checkState("shr");
    checkOutput("shr cout literal", 32'(cout), 1);

    // Same-edge write to addr_a: out captures the old value.
    applyStimulus(1'b1, 0, 1'b0, 0, 1, 0, 1'b1, 1'b1, 0);
    checkOutput("rw old r0", 32'(out), 'h01);
    readReg("rw new r0", 0);
    checkOutput("rw new r0 literal", 32'(out), 'h21);

`ifndef DATA_PATH_MUL_EN
    loadReg(1, 'h5A);
    applyStimulus(1'b1, 1, 1'b0, 1, 1, 2, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 7, 1'b0, 0, 1, 3, 1'b1, 1'b0, 0);
    checkState("pass_b");
    checkOutput("pass_b cout literal", 32'(cout), 0);
    readReg("pass_b r3", 3);
    checkOutput("pass_b r3 literal", 32'(out), 'h5A);
`else
    // MUL 0x10*0x11 with a read of r2 held on op_valid throughout.
    loadReg(0, 'h10);
    loadReg(1, 'h11);
    loadReg(2, 'h77);
    driveInputs(1'b1, 7, 1'b0, 0, 1, 2, 1'b1, 1'b1, 0);
    mOut = mRf[0];
    @(posedge clk);
    #1;
    driveInputs(1'b1, 0, 1'b1, 2, 0, 0, 1'b0, 1'b1, 0);
    lowCycles = 0;
    heldEarly = 1'b0;
    while (op_ready !== 1'b1 && lowCycles < 4 * W) begin
      lowCycles++;
      if (out !== 8'h10) heldEarly = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("mul stall cycles", lowCycles, W);
    checkOutput("mul held op waits", 32'(heldEarly), 0);
    mRf[2] = 'h10;
    mCout  = 1;
    mZero  = 0;
    checkState("mul result");
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    mOut = mRf[2];
    checkOutput("mul held op accepted", 32'(out), 'h10);

    // Reset in the middle of a multiply aborts it.
    loadReg(2, 0);
    driveInputs(1'b1, 7, 1'b0, 0, 1, 2, 1'b1, 1'b0, 0);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    checkOutput("mul abort op_ready low", 32'(op_ready), 0);
    rst_n = 1'b1;
    #1;
    checkState("mul abort");
    readReg("mul abort r2", 2);
    checkOutput("mul abort r2 literal", 32'(out), 0);
`endif

    for (int n = 0; n < 150; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      code = $urandom_range(0, 7);
      s    = $urandom_range(0, 1);
      aa   = $urandom_range(0, N - 1);
      ab   = $urandom_range(0, N - 1);
      aw   = $urandom_range(0, N - 1);
      we   = $urandom_range(0, 1);
      oe   = $urandom_range(0, 1);
      din  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, MASK);
`ifdef DATA_PATH_MUL_EN
      if (v && code == 7 && !s) begin
        runMul("rand mul", aa, ab, aw, we, oe);
        continue;
      end
`endif
      applyStimulus(v, code, s, aa, ab, aw, we, oe, din);
      checkState("rand");
    end
    for (int i = 0; i < N; i++) readReg("final rf", i);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
